// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Opcodes above XOR are reserved and reported through rsp_err.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op > 3'b100);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with zero/carry/overflow flags.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry_out,
    output logic              overflow
);

    logic [DATA_W:0] w_sum;

    // Operation decode; reserved opcodes yield an all-zero result.
    always_comb begin
        w_sum     = {(DATA_W+1){1'b0}};
        result    = {DATA_W{1'b0}};
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (op)
            ALU_ADD: begin
                w_sum     = {1'b0, a} + {1'b0, b};
                result    = w_sum[DATA_W-1:0];
                carry_out = w_sum[DATA_W];
                overflow  = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                // carry_out = 1 means no borrow
                w_sum     = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result    = w_sum[DATA_W-1:0];
                carry_out = w_sum[DATA_W];
                overflow  = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = {DATA_W{1'b0}};
        endcase
        zero = (result == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters with a
// fixed accept -> execute -> respond sequence.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [2:0]        op0,
    input  logic [2:0]        op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic [7:0]        op_count
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_grant;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_overflow;
    logic              r_err;
    logic [7:0]        r_count;

    logic              w_grant_sel;
    logic              w_accept;
    logic              w_handshake;
    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_carry;
    logic              w_overflow;

    alu u_alu (
        .a         (r_a),
        .b         (r_b),
        .op        (r_op),
        .result    (w_result),
        .zero      (w_zero),
        .carry_out (w_carry),
        .overflow  (w_overflow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grant selection and accept/handshake strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        req_ready   = 2'b00;
        if (req_valid == 2'b11) begin
            w_grant_sel = ~r_last_grant;
        end else if (req_valid[1]) begin
            w_grant_sel = 1'b1;
        end else begin
            w_grant_sel = 1'b0;
        end
        case (r_state)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held
                if ((req_valid != 2'b00) && rst_n) begin
                    w_accept    = 1'b1;
                    req_ready   = w_grant_sel ? 2'b10 : 2'b01;
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready[r_grant]) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping and operand capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= {DATA_W{1'b0}};
            r_b          <= {DATA_W{1'b0}};
            r_op         <= 3'b000;
        end else if (w_accept) begin
            r_grant      <= w_grant_sel;
            r_last_grant <= w_grant_sel;
            r_a          <= w_grant_sel ? a1 : a0;
            r_b          <= w_grant_sel ? b1 : b0;
            r_op         <= w_grant_sel ? op1 : op0;
        end
    end

    // Response registers: loaded in EXEC, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 2'b00;
            r_result    <= {DATA_W{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
            r_result    <= w_result;
            r_zero      <= w_zero;
            r_carry     <= w_carry;
            r_overflow  <= w_overflow;
            r_err       <= is_illegal_op(r_op);
        end else if (w_handshake) begin
            r_rsp_valid <= 2'b00;
        end
    end

    // Completed-response counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'h00;
        end else if (w_handshake) begin
            r_count <= r_count + 8'h01;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_result;
    assign rsp_zero     = r_zero;
    assign rsp_carry    = r_carry;
    assign rsp_overflow = r_overflow;
    assign rsp_err      = r_err;
    assign op_count     = r_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed corner cases plus a
// randomized run scored against an arithmetic reference model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] a0, b0, a1, b1;
    logic [2:0] op0, op1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero, rsp_carry, rsp_overflow, rsp_err;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;
    int exp_last;
    int exp_count;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .a0           (a0),
        .b0           (b0),
        .a1           (a1),
        .b1           (b1),
        .op0          (op0),
        .op1          (op1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .op_count     (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU using signed/unsigned integer arithmetic.
    task automatic model_alu(input int a, input int b, input int op,
                             output int res, output int z, output int c,
                             output int v, output int e);
        int sa, sb, t;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = 0; c = 0; v = 0; e = 0;
        case (op)
            0: begin res = (a + b) % 256; c = int'((a + b) > 255); t = sa + sb; v = int'(t > 127 || t < -128); end
            1: begin res = (a - b + 256) % 256; c = int'(a >= b); t = sa - sb; v = int'(t > 127 || t < -128); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            default: begin res = 0; e = 1; end
        endcase
        z = int'(res == 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_flags", 32'({rsp_zero, rsp_carry, rsp_overflow, rsp_err}), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_last  = 1;
        exp_count = 0;
    endtask

    // One full transaction starting in IDLE, #1 after a rising edge.
    task automatic txn(input logic [1:0] v,
                       input logic [7:0] xa0, input logic [7:0] xb0, input logic [2:0] xo0,
                       input logic [7:0] xa1, input logic [7:0] xb1, input logic [2:0] xo1,
                       input int hold);
        int g, res, z, c, ov, e;
        req_valid = v;
        a0 = xa0; b0 = xb0; op0 = xo0;
        a1 = xa1; b1 = xb1; op1 = xo1;
        if (v == 2'b11) g = 1 - exp_last;
        else if (v[1]) g = 1;
        else g = 0;
        if (g == 0) model_alu(int'(xa0), int'(xb0), int'(xo0), res, z, c, ov, e);
        else        model_alu(int'(xa1), int'(xb1), int'(xo1), res, z, c, ov, e);
        #1;
        chk("grant", 32'(req_ready), (g == 0) ? 32'd1 : 32'd2);
        @(posedge clk);
        exp_last = g;
        #1;
        req_valid = 2'($urandom_range(0, 3));
        a0 = 8'($urandom); b0 = 8'($urandom); op0 = 3'($urandom);
        a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), (g == 0) ? 32'd1 : 32'd2);
        chk("rsp_result", 32'(rsp_result), 32'(res));
        chk("rsp_zcve", 32'({rsp_zero, rsp_carry, rsp_overflow, rsp_err}),
            32'(z * 8 + c * 4 + ov * 2 + e));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = (g == 0) ? 2'b10 : 2'b01;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), (g == 0) ? 32'd1 : 32'd2);
            chk("hold_result", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err}),
                32'(res * 16 + z * 8 + c * 4 + ov * 2 + e));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_op_count", 32'(op_count), 32'(exp_count));
        end
        rsp_ready = (g == 0) ? 2'b01 : 2'b10;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        req_valid = 2'b00;
        exp_count = (exp_count + 1) % 256;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(exp_count));
    endtask

    initial begin
        rst_n = 1'b0;
        a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        op0 = 3'b000; op1 = 3'b000;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        exp_last  = 1;
        exp_count = 0;

        do_reset();
        txn(2'b01, 8'h7F, 8'h01, 3'b000, 8'h00, 8'h00, 3'b000, 0);
        txn(2'b10, 8'h00, 8'h00, 3'b000, 8'h00, 8'h01, 3'b001, 0);
        txn(2'b01, 8'h5A, 8'h5A, 3'b100, 8'h00, 8'h00, 3'b000, 0);

        do_reset();
        for (int i = 0; i < 4; i++)
            txn(2'b11, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)),
                8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 0);
        txn(2'b01, 8'h80, 8'h01, 3'b001, 8'h00, 8'h00, 3'b000, 5);
        txn(2'b01, 8'h12, 8'h34, 3'b110, 8'h00, 8'h00, 3'b000, 0);

        do_reset();
        for (int i = 0; i < 256; i++)
            txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 3'($urandom),
                8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
        chk("op_count_wrap", 32'(op_count), 32'd0);

        // Reset pulse while a response is pending.
        req_valid = 2'b01;
        a0 = 8'h01; b0 = 8'h02; op0 = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("pre_rst_resp", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        rsp_ready = 2'b11;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_result", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_err}), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        rsp_ready = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        exp_last  = 1;
        exp_count = 0;
        txn(2'b11, 8'h05, 8'h03, 3'b001, 8'h09, 8'h09, 3'b010, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-004 SHALL expose: req_ready  out  2  per-requester accept strobe, at most one bit high.
REQ-005 SHALL expose: a0, b0 / a1, b1  in  8 each  operands of requester 0 / 1.
REQ-006 SHALL expose: op0 / op1  in  3 each  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-007 SHALL expose: rsp_valid  out  2  per-requester response valid, at most one bit high.
REQ-008 SHALL expose: rsp_ready  in  2  per-requester response accept.
REQ-009 SHALL expose: rsp_result  out  8, rsp_zero, rsp_carry, rsp_overflow, rsp_err  out  1 each; shared response bus, valid only while rsp_valid is nonzero.
REQ-010 SHALL expose: op_count  out  8  number of completed responses, wraps 0xFF -> 0x00.

Function
REQ-011 FSM SHALL have states IDLE, EXEC, RESP.
- IDLE: if any req_valid bit is high, grant one requester, pulse req_ready[g] that cycle, latch a/b/op of g into operand registers, go to EXEC; otherwise stay.
- EXEC: register the ALU outputs for the latched operands into the response registers, go to RESP.
- RESP: hold rsp_valid[g]; on rsp_ready[g], increment op_count and go to IDLE.
REQ-012 Arbitration SHALL be round-robin: the requester other than last_grant wins when both are valid; a lone valid requester always wins; last_grant updates on accept.
REQ-013 Latency SHALL be fixed: accept in cycle N, rsp_valid[g] high from cycle N+2.
REQ-014 req_ready SHALL be low in EXEC and RESP; no new request is accepted until the current response completes.
REQ-015 Response registers and rsp_valid SHALL stay stable while rsp_ready[g] is low; rsp_ready of the non-granted requester SHALL be ignored.
REQ-016 Arithmetic SHALL be 8-bit:
- ADD: result = a+b mod 256; carry = bit 8; overflow on same-sign operands with a sign change.
- SUB: result = a + ~b + 1; carry = 1 means no borrow; overflow on different-sign operands where the result sign differs from a.
- AND/OR/XOR: carry = 0, overflow = 0.
- Zero SHALL equal (result == 0) for every op.
REQ-017 Opcodes 101-111 SHALL complete normally with result 0x00, zero 1, carry 0, overflow 0, rsp_err 1; rsp_err SHALL be 0 for legal opcodes.
REQ-018 A request deasserted while the block is not in IDLE SHALL be neither accepted nor lost state; req_valid is sampled only in IDLE.
REQ-019 op_count SHALL increment exactly once per completed response handshake and wrap silently.

Reset
REQ-020 On rst_n low, regardless of clock, SHALL force: state IDLE, req_ready 0, rsp_valid 0, rsp_result 0x00, rsp_zero 0, rsp_carry 0, rsp_overflow 0, rsp_err 0, op_count 0x00, last_grant = 1 (requester 0 wins first).
REQ-021 Reset asserted during EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-022 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-023 Package alu_pkg SHALL hold the opcode enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR), the FSM state enum and the width constant DATA_W = 8.
REQ-024 SHALL instantiate exactly one alu sub-module (8-bit, combinational, ports a, b, op, result, zero, carry_out, overflow) fed from the operand registers.

Verification
REQ-025 ADD a0=0x7F, b0=0x01 -> rsp_result 0x80, zero 0, carry 0, overflow 1, rsp_valid[0] at accept+2.
REQ-026 SUB a1=0x00, b1=0x01 -> rsp_result 0xFF, carry 0, overflow 0, zero 0; XOR 0x5A^0x5A -> 0x00, zero 1.
REQ-027 Both req_valid high right after reset -> requester 0 served first, then requester 1; with both held, grants alternate 0,1,0,1.
REQ-028 rsp_ready low for 5 cycles in RESP -> rsp_valid and the response bus are held unchanged, req_ready stays 0, op_count increments only on the handshake.
REQ-029 op0 = 3'b110 -> result 0x00, zero 1, rsp_err 1; 256 completed ops -> op_count back to 0x00.
REQ-030 rst_n pulsed low during RESP -> all outputs reach reset values immediately, no response is delivered, next grant goes to requester 0.
